// File: rtl/tcb_vip_mem_stall_if.sv
// TCB link between a manager and the stall-capable memory model.
// The manager drives the request fields and the stall count.
// The memory drives ready and the response fields.
interface tcb_vip_mem_stall_if #(
  parameter int ADR = 32,
  parameter int DAT = 32,
  parameter int STW = 4
);
  localparam int BEW = DAT / 8;

  logic           vld;
  logic           rdy;
  logic           wen;
  logic [ADR-1:0] adr;
  logic [BEW-1:0] ben;
  logic [DAT-1:0] wdt;
  logic [STW-1:0] stl;
  logic           rvl;
  logic [DAT-1:0] rdt;
  logic           err;

  modport master (
    output vld, wen, adr, ben, wdt, stl,
    input  rdy, rvl, rdt, err
  );

  modport slave (
    input  vld, wen, adr, ben, wdt, stl,
    output rdy, rvl, rdt, err
  );
endinterface

// File: rtl/tcb_vip_mem_stall.sv
// Single-port TCB memory model with programmable wait states,
// out-of-range error responses and a DLY-deep response pipeline.
// Optional macro TCB_VIP_MEM_RANDOM_STALL_EN: the stall count becomes
// LFSR[STW-1:0] & stl, with stl acting as a mask.
//
// state | meaning
// IDLE  | no pending stall; rdy follows vld when the stall count is 0
// WAIT  | counting down wait states; rdy=1 once cnt reaches 0
module tcb_vip_mem_stall #(
  parameter int ADR = 32,
  parameter int DAT = 32,
  parameter int SIZ = 256,
  parameter int DLY = 1,
  parameter int STW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tcb_vip_mem_stall_if.slave   bus
);
  localparam int BEW = DAT / 8;
  localparam int AW  = $clog2(BEW);
  localparam int SW  = $clog2(SIZ);
  localparam int IW  = ADR - AW;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         r_state;
  logic [STW-1:0] r_cnt;
  logic [STW-1:0] w_stl_n;
  logic           w_rdy;
  logic           w_trn;
  logic [IW-1:0]  w_idx_full;
  logic [SW-1:0]  w_idx;
  logic           w_oor;
  logic [DAT-1:0] w_rword;
  logic [DAT-1:0] w_rdata;
  logic           w_v0;
  logic [DAT-1:0] w_d0;
  logic           w_e0;

  logic [DAT-1:0] r_mem [SIZ];

`ifdef TCB_VIP_MEM_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_lfsr <= 16'hACE1;
    else      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_stl_n = r_lfsr[STW-1:0] & bus.stl;
`else
  assign w_stl_n = bus.stl;
`endif

  // Address decode: low byte-lane bits dropped, upper bits must be zero
  assign w_idx_full = bus.adr[ADR-1:AW];
  assign w_idx      = w_idx_full[SW-1:0];
  generate
    if (IW > SW) begin : g_oor
      assign w_oor = |w_idx_full[IW-1:SW];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  // Ready is combinational so a zero-stall request completes in its first cycle;
  // gated by reset so it is low while reset is held.
  assign w_rdy = rst & (((r_state == IDLE) && bus.vld && (w_stl_n == '0)) ||
                        ((r_state == WAIT) && (r_cnt == '0)));
  assign w_trn = bus.vld & w_rdy;
  assign bus.rdy = w_rdy;

  // Stall FSM; stl is sampled only when leaving IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.vld && (w_stl_n != '0)) begin
            r_cnt   <= w_stl_n - STW'(1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - STW'(1);
          else if (bus.vld) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Byte-masked write; memory is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_trn && bus.wen && !w_oor) begin
      for (int b = 0; b < BEW; b++) begin
        if (bus.ben[b]) r_mem[w_idx][8*b +: 8] <= bus.wdt[8*b +: 8];
      end
    end
  end

  // Read sees the array after the previous edge's write; disabled lanes read 0
  always_comb begin
    w_rword = r_mem[w_idx];
    w_rdata = '0;
    for (int b = 0; b < BEW; b++) begin
      if (bus.ben[b]) w_rdata[8*b +: 8] = w_rword[8*b +: 8];
    end
  end

  assign w_v0 = w_trn;
  assign w_e0 = w_trn & w_oor;
  assign w_d0 = (w_trn && !bus.wen && !w_oor) ? w_rdata : '0;

  generate
    if (DLY == 0) begin : g_dly0
      assign bus.rvl = w_v0;
      assign bus.rdt = w_d0;
      assign bus.err = w_e0;
    end else begin : g_dlyn
      logic [DLY-1:0] r_vl_pipe;
      logic [DLY-1:0] r_er_pipe;
      logic [DAT-1:0] r_dt_pipe [DLY];

      // Response shift register; every stage cleared on reset
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vl_pipe <= '0;
          r_er_pipe <= '0;
          for (int i = 0; i < DLY; i++) r_dt_pipe[i] <= '0;
        end else begin
          r_vl_pipe[0] <= w_v0;
          r_er_pipe[0] <= w_e0;
          r_dt_pipe[0] <= w_d0;
          for (int i = 1; i < DLY; i++) begin
            r_vl_pipe[i] <= r_vl_pipe[i-1];
            r_er_pipe[i] <= r_er_pipe[i-1];
            r_dt_pipe[i] <= r_dt_pipe[i-1];
          end
        end
      end

      assign bus.rvl = r_vl_pipe[DLY-1];
      assign bus.rdt = r_dt_pipe[DLY-1];
      assign bus.err = r_er_pipe[DLY-1];
    end
  endgenerate
endmodule

// File: doc/tcb_vip_mem_stall.md
Name: tcb_vip_mem_stall

Overview:
- Parametrised single-port TCB memory model; next generation of the VIP memory.
- Adds three features the current model lacks:
  - programmable backpressure (wait states on rdy);
  - error responses for out-of-range accesses;
  - a response-valid pipeline with a deterministic reset state.
- Sits at the subordinate end of a TCB link in testbenches and small SoC sims.
- Written as synthesizable RTL so it can also back FPGA prototypes.

Parameters:
- ADR, 32, address width in bits (byte address).
- DAT, 32, data width in bits; BEW = DAT/8 byte enables; DAT must be a power of 2, at least 8.
- SIZ, 256, memory depth in words (power of 2); valid byte range is 0 to SIZ*BEW-1.
- DLY, 1, read/response latency in cycles after transfer; range 0 to 4.
- STW, 4, width of the stall-count input.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- vld  in  1  request valid.
- rdy  out  1  request ready (backpressure).
- wen  in  1  write enable (1 = write, 0 = read).
- adr  in  ADR  byte address.
- ben  in  BEW  byte enables.
- wdt  in  DAT  write data.
- stl  in  STW  wait states inserted before each request is accepted.
- rvl  out  1  response valid.
- rdt  out  DAT  read data.
- err  out  1  error response; valid when rvl=1.

Behaviour:
- Transfer: trn = vld & rdy. The manager holds the request stable while vld=1 and rdy=0.
- Reset values:
  - FSM returns to IDLE; wait counter cnt = 0.
  - rdy = 0, rvl = 0, rdt = 0, err = 0; the whole response pipeline is cleared.
  - Memory contents are not reset; a reset mid-operation preserves memory.
- FSM states IDLE and WAIT:
  - IDLE, vld=1, stl=0: rdy=1 combinationally; the transfer occurs this cycle and the FSM stays in IDLE.
  - IDLE, vld=1, stl=N>0: rdy=0; load cnt=N-1; go to WAIT. stl is sampled only on this entry.
  - WAIT, cnt>0: rdy=0; cnt decrements.
  - WAIT, cnt=0: rdy=1; the transfer occurs (vld is required high) and the FSM returns to IDLE.
  - Result: exactly N idle cycles with rdy=0 precede the transfer cycle.
  - IDLE, vld=0: rdy=0; no state change.
  - A new request immediately after a transfer starts again from IDLE and samples stl anew.
- Word index = adr[ADR-1:log2(BEW)]. Low address bits are ignored; ben is word-aligned.
- Out of range (word index >= SIZ):
  - err=1 in the response; writes are suppressed.
  - rdt=0 for that response.
  - No wrap-around: aliasing is forbidden.
- Write: on trn with wen=1, each byte with ben[b]=1 is written at the clk edge. Bytes with ben[b]=0 are unchanged. rdt=0 in the response.
- Read: on trn with wen=0, the word is read in the transfer cycle:
  - bytes with ben[b]=0 return 0 (not X);
  - ben=0 is legal and returns 0 with err=0.
- Ordering: write then read of the same word in back-to-back transfers returns the new data. Read is sampled after the preceding edge's write.
- Response pipeline: rvl/rdt/err appear exactly DLY cycles after the trn cycle.
  - DLY=0: combinational outputs in the trn cycle.
  - Every transfer produces exactly one rvl pulse, including writes and errors.
  - With no transfer, rvl=0 and rdt/err are driven 0.
- Back-to-back transfers (stl=0, vld held) sustain 1 transfer/cycle and produce consecutive rvl pulses.

Optional Feature:
- Macro: TCB_VIP_MEM_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every clk.
  - On IDLE entry with vld=1, the stall count is N = LFSR[STW-1:0] & stl. stl acts as a mask; stl=0 still gives zero stalls.
- Undefined: N = stl exactly and no LFSR is instantiated.

Test Plan:
- stl=0, DLY=1: write adr=0x10, ben=4'hF, wdt=0xDEADBEEF, then read adr=0x10 -> rdy=1 both cycles; read rvl one cycle after trn with rdt=0xDEADBEEF, err=0.
- stl=3: single read request held -> rdy low for exactly 3 cycles, high on 4th; rvl DLY cycles later.
- Partial write ben=4'b0101, wdt=0x11223344 over 0xDEADBEEF, then read ben=4'b1100 -> rdt=0xDE220000.
- SIZ=256: write adr=0x400 (word 256), wdt=0x12345678 -> err=1, rdt=0; then read adr=0x0 -> word 0 unchanged.
- DLY=3, stl=0: 4 back-to-back reads of words 0..3 -> 4 consecutive rvl pulses starting 3 cycles after the first trn, data in order.
- Assert rst=0 while in WAIT with cnt=2 and a response in flight -> rdy, rvl, rdt and err go 0 immediately; after release, previously written data still reads back.
